serial_alu_ctrl: RTL and testbench

SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

---
 rtl/alu_pkg.sv | 20 ++
 rtl/serial_alu_ctrl_one_bit_alu.sv | 25 ++
 rtl/serial_alu_ctrl.sv | 128 ++++++++++++
 tb/tb_serial_alu_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU controller: ALU op codes and FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } alu_state_e;

    // Operation code presented to the one-bit stage for the arithmetic path.
    localparam logic [1:0] STAGE_OP_SUM = 2'd2;

endpackage

// File: rtl/serial_alu_ctrl_one_bit_alu.sv
// One-bit ALU slice: AND / OR / full-add of a and (optionally inverted) b.
module one_bit_ALU (
    input  logic       a_i,
    input  logic       b_i,
    input  logic       carry_i,
    input  logic       binvert_i,
    input  logic [1:0] operation_i,
    output logic       result_o,
    output logic       carry_o
);

    logic b_eff;

    always_comb begin
        b_eff   = b_i ^ binvert_i;
        carry_o = (a_i & b_eff) | (a_i & carry_i) | (b_eff & carry_i);
        unique case (operation_i)
            2'd0:    result_o = a_i & b_eff;
            2'd1:    result_o = a_i | b_eff;
            2'd2:    result_o = a_i ^ b_eff ^ carry_i;
            default: result_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU controller (AND/OR/ADD/SUB), one bit per cycle LSB first.
// Define SERIAL_ALU_OVF_EN to enable the signed-overflow flag; otherwise overflow is tied to 0.
module serial_alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    alu_state_e       state_q;
    alu_op_e          op_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, res_sh_q, res_d;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             busy_q, done_q, carry_out_q, zero_q;
    logic [WIDTH-1:0] result_q;
    logic             stage_res, stage_cout, stage_binv;
    logic [1:0]       stage_op;

    always_comb begin
        stage_binv = (op_q == OP_SUB);
        stage_op   = (op_q == OP_SUB) ? STAGE_OP_SUM : logic'(1'b0) ? 2'd0 : 2'(op_q);
        res_d      = {stage_res, res_sh_q[WIDTH-1:1]};
    end

    one_bit_ALU u_stage (
        .a_i         (a_sh_q[0]),
        .b_i         (b_sh_q[0]),
        .carry_i     (carry_q),
        .binvert_i   (stage_binv),
        .operation_i (stage_op),
        .result_o    (stage_res),
        .carry_o     (stage_cout)
    );

`ifdef SERIAL_ALU_OVF_EN
    logic overflow_q;

    // carry_q holds the carry into the MSB during the final bit-cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (state_q == RUN && cnt_q == CNT_LAST) begin
            overflow_q <= op_q[1] & (carry_q ^ stage_cout);
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_AND;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_sh_q    <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b1;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        op_q    <= alu_op_e'(op);
                        cnt_q   <= '0;
                        carry_q <= (op == OP_SUB);
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    res_sh_q <= res_d;
                    carry_q  <= stage_cout;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        result_q    <= res_d;
                        carry_out_q <= op_q[1] & stage_cout;
                        zero_q      <= (res_d == '0);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed self-checking bench for serial_alu_ctrl at WIDTH=16.
module tb_serial_alu_ctrl;

`ifdef SERIAL_ALU_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a, b;
    logic [1:0]  op;
    logic        busy, done, carry_out, zero, overflow;
    logic [15:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    serial_alu_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .op        (op),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one operation and return the number of rising edges from driving start to seeing done.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic [1:0] top,
                         output int lat);
        @(negedge clk);
        a = ta; b = tb; op = top; start = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
        end while (!done && lat < 40);
    endtask

    task automatic check_flags(input string tag, input logic [15:0] r, input logic co,
                               input logic z, input logic ov);
        check({tag, "_result"}, 32'(result), 32'(r));
        check({tag, "_carry"}, 32'(carry_out), 32'(co));
        check({tag, "_zero"}, 32'(zero), 32'(z));
        check({tag, "_ovf"}, 32'(overflow), 32'(ov));
    endtask

    initial begin
        int lat;
        int ndone;
        int t_first, t_second;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; op = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_flags("rst", 16'h0000, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;

        do_op(16'h7FFF, 16'h0001, 2'b10, lat);
        check("add_ovf_lat", 32'(lat), 32'd17);
        check_flags("add_ovf", 16'h8000, 1'b0, 1'b0, OVF_ON);
        @(negedge clk);
        check("add_ovf_done_pulse", 32'(done), 32'd0);
        check("add_ovf_busy_after", 32'(busy), 32'd0);

        do_op(16'h0005, 16'h0005, 2'b11, lat);
        check_flags("sub_eq", 16'h0000, 1'b1, 1'b1, 1'b0);

        do_op(16'hFFFF, 16'h0001, 2'b10, lat);
        check_flags("add_wrap", 16'h0000, 1'b1, 1'b1, 1'b0);

        do_op(16'h8000, 16'h0001, 2'b11, lat);
        check_flags("sub_ovf", 16'h7FFF, 1'b1, 1'b0, OVF_ON);

        do_op(16'h0003, 16'h0005, 2'b11, lat);
        check_flags("sub_neg", 16'hFFFE, 1'b0, 1'b0, 1'b0);

        do_op(16'hF0F0, 16'h3C3C, 2'b00, lat);
        check_flags("and", 16'h3030, 1'b0, 1'b0, 1'b0);

        do_op(16'hF0F0, 16'h3C3C, 2'b01, lat);
        check_flags("or", 16'hFCFC, 1'b0, 1'b0, 1'b0);

        // Start re-pulsed mid-RUN must be ignored.
        @(negedge clk);
        a = 16'h0001; b = 16'h0002; op = 2'b10; start = 1'b1;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == 3) check("ign_busy_run", 32'(busy), 32'd1);
            if (i == 5) begin a = 16'hFFFF; start = 1'b1; end
            if (i == 6) start = 1'b0;
            if (done) ndone++;
        end
        check("ign_ndone", 32'(ndone), 32'd1);
        check("ign_result", 32'(result), 32'h0003);
        check("ign_busy_after", 32'(busy), 32'd0);

        // Asynchronous reset in RUN cycle 8, checked between clock edges.
        @(negedge clk);
        a = 16'hAAAA; b = 16'h0001; op = 2'b10; start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        check("arst_busy_pre", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check_flags("arst", 16'h0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        do_op(16'h1234, 16'h1111, 2'b10, lat);
        check("post_rst_lat", 32'(lat), 32'd17);
        check_flags("post_rst", 16'h2345, 1'b0, 1'b0, 1'b0);

        // Start held through DONE gives back-to-back operations.
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; op = 2'b10; start = 1'b1;
        t_first = -1; t_second = -1;
        for (int i = 1; i <= 60 && t_second < 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                if (t_first < 0) t_first = i;
                else begin t_second = i; start = 1'b0; end
            end
        end
        check("b2b_first", 32'(t_first), 32'd17);
        check("b2b_gap", 32'(t_second - t_first), 32'd17);
        check("b2b_result", 32'(result), 32'h0002);
        @(negedge clk);
        check("b2b_busy_end", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
